// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants, state encoding and frame payload for the UART command parser.
package uart_cmd_parser_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] SYNC_BYTE    = 8'hA5;
  localparam logic [BYTE_W-1:0] RESP_BYTE    = 8'h5A;

  localparam logic [BYTE_W-1:0] CMD_WRITE    = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_READ     = 8'h02;

  localparam logic [BYTE_W-1:0] STAT_OK      = 8'h00;
  localparam logic [BYTE_W-1:0] STAT_BAD_CHK = 8'h01;
  localparam logic [BYTE_W-1:0] STAT_BAD_CMD = 8'h02;

  typedef enum logic [3:0] {
    ST_HUNT,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_CHK,
    ST_EXEC,
    ST_WAIT_RD,
    ST_RESP0,
    ST_RESP1,
    ST_RESP2
  } state_e;

  // Latched body of a command frame (everything between SYNC and CHK).
  typedef struct packed {
    logic [BYTE_W-1:0] cmd;
    logic [BYTE_W-1:0] addr;
    logic [BYTE_W-1:0] data;
  } frame_t;

  function automatic logic [BYTE_W-1:0] frame_chk(input frame_t f);
    return f.cmd ^ f.addr ^ f.data;
  endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// UART command parser: assembles 5-byte frames (A5 CMD ADDR DATA CHK) from the
// RX FIFO, performs an 8-bit register read/write and returns a 3-byte response
// (5A STATUS RDATA) to the TX FIFO.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   rx_data/rx_valid/rx_ready    RX FIFO (rx_ready is the combinational pop)
//   tx_data/tx_valid/tx_ready    TX FIFO push
//   reg_addr/reg_wdata/reg_we/reg_re/reg_rdata   register bus
//   frame_count, err_count       status counters
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 60_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 60_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [7:0]  reg_rdata,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  // Reject parameter sets the timeout logic cannot honour.
  if (TIMEOUT_CYCLES < 16 || CLK_FREQ == 0) begin : g_param_check
    $error("uart_cmd_parser: TIMEOUT_CYCLES must be >= 16 and CLK_FREQ nonzero");
  end

  state_e            state_q, state_d;
  logic              fetch_pending_q, fetch_pending_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  frame_t            frame_q, frame_d;
  logic [7:0]        status_q, status_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [7:0]        err_count_q, err_count_d;

  logic              in_frame;
  logic              receiving;
  logic              timeout_hit;
  logic              err_inc;

  assign receiving = (state_q inside {ST_HUNT, ST_CMD, ST_ADDR, ST_DATA, ST_CHK});
  assign in_frame  = (state_q inside {ST_CMD, ST_ADDR, ST_DATA, ST_CHK});
  assign rx_ready  = rx_valid && receiving && !fetch_pending_q;

  // A byte sampled this cycle beats an expiring timeout.
  assign timeout_hit = in_frame && !fetch_pending_q &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d         = state_q;
    fetch_pending_d = rx_ready;
    to_cnt_d        = '0;
    frame_d         = frame_q;
    status_d        = status_q;
    rdata_d         = rdata_q;
    reg_we_d        = 1'b0;
    reg_re_d        = 1'b0;
    frame_count_d   = frame_count_q;
    err_count_d     = err_count_q;
    err_inc         = 1'b0;
    tx_valid_d      = 1'b0;
    tx_data_d       = '0;

    if (in_frame && !fetch_pending_q) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    case (state_q)
      ST_HUNT: begin
        if (fetch_pending_q && rx_data == SYNC_BYTE) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (fetch_pending_q) begin
          frame_d.cmd = rx_data;
          state_d     = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (fetch_pending_q) begin
          frame_d.addr = rx_data;
          state_d      = ST_DATA;
        end
      end
      ST_DATA: begin
        if (fetch_pending_q) begin
          frame_d.data = rx_data;
          state_d      = ST_CHK;
        end
      end
      // Frame is judged as CHK arrives so the strobe can be registered for EXEC.
      ST_CHK: begin
        if (fetch_pending_q) begin
          state_d = ST_EXEC;
          rdata_d = '0;
          if (rx_data != frame_chk(frame_q)) begin
            status_d = STAT_BAD_CHK;
          end else if (frame_q.cmd == CMD_WRITE) begin
            status_d = STAT_OK;
            rdata_d  = frame_q.data;
            reg_we_d = 1'b1;
          end else if (frame_q.cmd == CMD_READ) begin
            status_d = STAT_OK;
            reg_re_d = 1'b1;
          end else begin
            status_d = STAT_BAD_CMD;
          end
        end
      end
      ST_EXEC: begin
        if (status_q != STAT_OK) begin
          err_inc = 1'b1;
          state_d = ST_RESP0;
        end else begin
          frame_count_d = frame_count_q + 16'd1;
          state_d       = reg_re_q ? ST_WAIT_RD : ST_RESP0;
        end
      end
      ST_WAIT_RD: begin
        rdata_d = reg_rdata;
        state_d = ST_RESP0;
      end
      ST_RESP0: if (tx_valid_q && tx_ready) state_d = ST_RESP1;
      ST_RESP1: if (tx_valid_q && tx_ready) state_d = ST_RESP2;
      ST_RESP2: if (tx_valid_q && tx_ready) state_d = ST_HUNT;
      default:  state_d = ST_HUNT;
    endcase

    if (timeout_hit) begin
      state_d  = ST_HUNT;
      to_cnt_d = '0;
      err_inc  = 1'b1;
    end

    if (err_inc && err_count_q != 8'hFF) begin
      err_count_d = err_count_q + 8'd1;
    end

    // TX byte follows the state being entered so it is ready from its first cycle.
    case (state_d)
      ST_RESP0: begin tx_valid_d = 1'b1; tx_data_d = RESP_BYTE; end
      ST_RESP1: begin tx_valid_d = 1'b1; tx_data_d = status_d;  end
      ST_RESP2: begin tx_valid_d = 1'b1; tx_data_d = rdata_d;   end
      default:  begin tx_valid_d = 1'b0; tx_data_d = '0;        end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_HUNT;
      fetch_pending_q <= 1'b0;
      to_cnt_q        <= '0;
      frame_q         <= '0;
      status_q        <= '0;
      rdata_q         <= '0;
      tx_data_q       <= '0;
      tx_valid_q      <= 1'b0;
      reg_we_q        <= 1'b0;
      reg_re_q        <= 1'b0;
      frame_count_q   <= '0;
      err_count_q     <= '0;
    end else begin
      state_q         <= state_d;
      fetch_pending_q <= fetch_pending_d;
      to_cnt_q        <= to_cnt_d;
      frame_q         <= frame_d;
      status_q        <= status_d;
      rdata_q         <= rdata_d;
      tx_data_q       <= tx_data_d;
      tx_valid_q      <= tx_valid_d;
      reg_we_q        <= reg_we_d;
      reg_re_q        <= reg_re_d;
      frame_count_q   <= frame_count_d;
      err_count_q     <= err_count_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign reg_addr    = frame_q.addr;
  assign reg_wdata   = frame_q.data;
  assign reg_we      = reg_we_q;
  assign reg_re      = reg_re_q;
  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: frames are issued with random gaps and
// TX backpressure; expected responses and register strobes are queued by a
// behavioural model and checked by an independent monitor.
module tb_uart_cmd_parser;

  localparam int unsigned TO = 200;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [7:0]  reg_rdata;
  logic [15:0] frame_count;
  logic [7:0]  err_count;

  uart_cmd_parser #(.CLK_FREQ(60_000_000), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .frame_count(frame_count), .err_count(err_count)
  );

  int total;
  int bad;
  int exp_frames;
  int exp_err;
  logic [7:0]  model_mem [256];
  logic [7:0]  tx_q [$];
  logic [15:0] wr_q [$];
  logic [7:0]  rd_q [$];

  bit          bp_test;
  int          hold_cnt;
  int          resp_idx;

  logic [7:0]  mem [256];
  bit          mem_init;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a ^ 8'h5C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog");
  end

  // Register bus slave: read data is valid exactly the cycle after reg_re.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
      mem_init <= 1'b1;
    end else if (reg_we) begin
      mem[reg_addr] <= reg_wdata;
    end
    reg_rdata <= reg_re ? mem[reg_addr] : 8'($urandom);
  end

  // TX FIFO readiness: random, or a 20-cycle stall on the status byte.
  initial begin
    tx_ready = 1'b0;
    hold_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!bp_test) begin
        hold_cnt = 0;
        tx_ready = ($urandom_range(0, 3) != 0);
      end else if (resp_idx == 1 && tx_valid && hold_cnt < 20) begin
        tx_ready = 1'b0;
        hold_cnt++;
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  // Monitor: compares every accepted TX byte and every register strobe.
  logic       prev_v, prev_r, prev_we, prev_re;
  logic [7:0] prev_d;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0; prev_r = 1'b0; prev_we = 1'b0; prev_re = 1'b0; prev_d = '0;
      resp_idx = 0;
    end else begin
      if (reg_we && reg_re) check("strobe_exclusive", 32'({reg_we, reg_re}), 32'h1);
      if (reg_we) begin
        total++;
        if (wr_q.size() == 0 || prev_we) begin
          bad++;
          $display("FAIL reg_we: got strobe addr 0x%0h data 0x%0h expected none", reg_addr, reg_wdata);
        end else begin
          logic [15:0] e;
          e = wr_q.pop_front();
          if ({reg_addr, reg_wdata} !== e) begin
            bad++;
            $display("FAIL reg_write: got 0x%0h expected 0x%0h", {reg_addr, reg_wdata}, e);
          end
        end
      end
      if (reg_re) begin
        total++;
        if (rd_q.size() == 0 || prev_re) begin
          bad++;
          $display("FAIL reg_re: got strobe addr 0x%0h expected none", reg_addr);
        end else begin
          logic [7:0] e;
          e = rd_q.pop_front();
          if (reg_addr !== e) begin
            bad++;
            $display("FAIL reg_read_addr: got 0x%0h expected 0x%0h", reg_addr, e);
          end
        end
      end
      if (prev_v && !prev_r) begin
        check("tx_hold", 32'({tx_valid, tx_data}), 32'({1'b1, prev_d}));
      end
      if (tx_valid && tx_ready) begin
        total++;
        if (tx_q.size() == 0) begin
          bad++;
          $display("FAIL tx_unexpected: got byte 0x%0h expected none", tx_data);
        end else begin
          logic [7:0] e;
          e = tx_q.pop_front();
          if (tx_data !== e) begin
            bad++;
            $display("FAIL tx_byte: got 0x%0h expected 0x%0h", tx_data, e);
          end
        end
        resp_idx = (resp_idx + 1) % 3;
      end
      prev_v = tx_valid; prev_r = tx_ready; prev_d = tx_data;
      prev_we = reg_we; prev_re = reg_re;
    end
  end

  // Presents one byte as an RX FIFO with one-cycle read latency.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    @(negedge clk);
    while (!rx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      total++; bad++;
      $display("FAIL rx_pop: got no pop expected pop of 0x%0h", b);
    end
    @(posedge clk); #1;
    rx_valid = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Model: expected strobes and response derived from the frame rules.
  task automatic issue_frame(input logic [7:0] c, input logic [7:0] a,
                             input logic [7:0] d, input logic [7:0] k);
    logic [7:0] st, rd;
    rd = 8'h00;
    if (k != (c ^ a ^ d)) begin
      st = 8'h01;
      if (exp_err < 255) exp_err++;
    end else if (c == 8'h01) begin
      st = 8'h00; rd = d;
      model_mem[a] = d;
      wr_q.push_back({a, d});
      exp_frames++;
    end else if (c == 8'h02) begin
      st = 8'h00; rd = model_mem[a];
      rd_q.push_back(a);
      exp_frames++;
    end else begin
      st = 8'h02;
      if (exp_err < 255) exp_err++;
    end
    tx_q.push_back(8'h5A);
    tx_q.push_back(st);
    tx_q.push_back(rd);
    send_byte(8'hA5, $urandom_range(0, 3));
    send_byte(c, $urandom_range(0, 3));
    send_byte(a, $urandom_range(0, 3));
    send_byte(d, $urandom_range(0, 3));
    send_byte(k, $urandom_range(0, 3));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((tx_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL drain: got %0d bytes outstanding expected 0", tx_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("reset_bus", 32'({tx_data, tx_valid, rx_ready, reg_addr, reg_wdata, reg_we, reg_re}), 32'h0);
    check("reset_counters", 32'({frame_count, err_count}), 32'h0);
  endtask

  initial begin
    logic [7:0] c, a, d, k;
    int r;
    total = 0; bad = 0; exp_frames = 0; exp_err = 0;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; bp_test = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = init_val(8'(i));
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic write.
    issue_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
    drain();
    check("write_frame_count", 32'(frame_count), 32'(exp_frames & 16'hFFFF));
    check("write_addr_data", 32'({reg_addr, reg_wdata}), 32'h103C);

    // Read returning 0x77.
    issue_frame(8'h01, 8'h10, 8'h77, 8'h66);
    issue_frame(8'h02, 8'h10, 8'h00, 8'h12);
    drain();
    check("read_frame_count", 32'(frame_count), 32'(exp_frames & 16'hFFFF));

    // Checksum and command errors.
    issue_frame(8'h01, 8'h10, 8'h3C, 8'h00);
    drain();
    check("chk_err_count", 32'(err_count), 32'(exp_err));
    issue_frame(8'h07, 8'h00, 8'h00, 8'h07);
    drain();
    check("cmd_err_count", 32'(err_count), 32'(exp_err));

    // Junk before a frame is discarded.
    send_byte(8'h00, 1);
    send_byte(8'hFF, 0);
    send_byte(8'h3C, 2);
    issue_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
    drain();
    check("resync_frame_count", 32'(frame_count), 32'(exp_frames & 16'hFFFF));

    // Inter-byte timeout.
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    repeat (TO + 5) @(posedge clk);
    #1;
    if (exp_err < 255) exp_err++;
    drain();
    check("timeout_err_count", 32'(err_count), 32'(exp_err));
    issue_frame(8'h01, 8'h20, 8'h55, 8'h74);
    drain();
    check("post_timeout_frames", 32'(frame_count), 32'(exp_frames & 16'hFFFF));

    // Status byte stalled for 20 cycles.
    bp_test = 1'b1;
    issue_frame(8'h02, 8'h20, 8'h00, 8'h22);
    drain();
    check("stall_cycles", 32'(hold_cnt), 32'd20);
    bp_test = 1'b0;

    // Reset mid-frame.
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    exp_frames = 0; exp_err = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue_frame(8'h01, 8'h30, 8'h99, 8'hA8);
    drain();
    check("post_reset_frames", 32'(frame_count), 32'(exp_frames & 16'hFFFF));

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      c = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : 8'($urandom);
      a = 8'($urandom);
      d = 8'($urandom);
      k = c ^ a ^ d;
      if ($urandom_range(0, 6) == 0) k = k ^ 8'($urandom_range(1, 255));
      issue_frame(c, a, d, k);
    end
    drain();
    check("random_frames", 32'(frame_count), 32'(exp_frames & 16'hFFFF));
    check("random_errors", 32'(err_count), 32'(exp_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
